// File: rtl/plugboard_config_ctrl.sv
// ============================================================================
//  Module      : plugboard_config_ctrl
//  Description : Runtime-programmable plugboard swap map with a command port
//                for add/remove/clear and two combinational lookup ports.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module plugboard_config_ctrl #(
    parameter int MAX_PAIRS = 10,
    parameter int N_LETTERS = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [4:0] cmd_a,
    input  logic [4:0] cmd_b,
    output logic       rsp_valid,
    output logic [2:0] rsp_status,
    output logic [3:0] pair_count,
    output logic       cfg_busy,
    input  logic [4:0] lookup_in_0,
    output logic [4:0] lookup_out_0,
    input  logic [4:0] lookup_in_1,
    output logic [4:0] lookup_out_1
);

    localparam logic [4:0] LAST_LETTER = 5'(N_LETTERS - 1);
    localparam logic [3:0] PAIR_LIMIT  = 4'(MAX_PAIRS);

    localparam logic [1:0] OP_NOP    = 2'd0;
    localparam logic [1:0] OP_ADD    = 2'd1;
    localparam logic [1:0] OP_REMOVE = 2'd2;
    localparam logic [1:0] OP_CLEAR  = 2'd3;

    localparam logic [2:0] ST_OK         = 3'd0;
    localparam logic [2:0] ST_RANGE      = 3'd1;
    localparam logic [2:0] ST_SELF       = 3'd2;
    localparam logic [2:0] ST_BUSY       = 3'd3;
    localparam logic [2:0] ST_FULL       = 3'd4;
    localparam logic [2:0] ST_NOT_PAIRED = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        CLEAR = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nx;

    logic [4:0] map [N_LETTERS];
    logic [1:0] op_q;
    logic [4:0] a_q;
    logic [4:0] b_q;
    logic [4:0] clr_idx;

    logic       accept;
    logic [4:0] map_a;
    logic [4:0] map_b;
    logic [2:0] exec_status;
    logic       do_add;
    logic       do_rem;

    assign cmd_ready = (state == IDLE);
    assign cfg_busy  = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = cmd_valid & cmd_ready;

    assign lookup_out_0 = (lookup_in_0 <= LAST_LETTER) ? map[lookup_in_0] : lookup_in_0;
    assign lookup_out_1 = (lookup_in_1 <= LAST_LETTER) ? map[lookup_in_1] : lookup_in_1;

    // Out-of-range operands read back as themselves so no array read leaves the table
    assign map_a = (a_q <= LAST_LETTER) ? map[a_q] : a_q;
    assign map_b = (b_q <= LAST_LETTER) ? map[b_q] : b_q;

    always_comb begin
        exec_status = ST_OK;
        do_add      = 1'b0;
        do_rem      = 1'b0;
        case (op_q)
            OP_ADD: begin
                if (a_q > LAST_LETTER || b_q > LAST_LETTER) exec_status = ST_RANGE;
                else if (a_q == b_q)                         exec_status = ST_SELF;
                else if (map_a != a_q || map_b != b_q)       exec_status = ST_BUSY;
                else if (pair_count == PAIR_LIMIT)           exec_status = ST_FULL;
                else                                         do_add      = 1'b1;
            end
            OP_REMOVE: begin
                if (a_q > LAST_LETTER)  exec_status = ST_RANGE;
                else if (map_a == a_q)  exec_status = ST_NOT_PAIRED;
                else                    do_rem      = 1'b1;
            end
            default: exec_status = ST_OK;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (cmd_op == OP_CLEAR) ? CLEAR : EXEC;
            EXEC:    state_nx = RESP;
            CLEAR:   if (clr_idx == LAST_LETTER) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_NOP;
            a_q        <= 5'd0;
            b_q        <= 5'd0;
            clr_idx    <= 5'd0;
            rsp_status <= ST_OK;
            pair_count <= 4'd0;
        end else begin
            if (accept) begin
                op_q    <= cmd_op;
                a_q     <= cmd_a;
                b_q     <= cmd_b;
                clr_idx <= 5'd0;
            end
            if (state == EXEC) begin
                rsp_status <= exec_status;
                if (do_add) pair_count <= pair_count + 4'd1;
                if (do_rem) pair_count <= pair_count - 4'd1;
            end
            if (state == CLEAR) begin
                clr_idx <= clr_idx + 5'd1;
                if (clr_idx == LAST_LETTER) begin
                    pair_count <= 4'd0;
                    rsp_status <= ST_OK;
                end
            end
        end
    end

    // Both halves of a pair change on the same edge, keeping the map an involution
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_LETTERS; i++) map[i] <= 5'(i);
        end else begin
            if (state == EXEC && do_add) begin
                map[a_q] <= b_q;
                map[b_q] <= a_q;
            end
            if (state == EXEC && do_rem) begin
                map[a_q]   <= a_q;
                map[map_a] <= map_a;
            end
            if (state == CLEAR) map[clr_idx] <= clr_idx;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_plugboard_config_ctrl.sv
// ============================================================================
//  Module      : tb_plugboard_config_ctrl
//  Description : Directed plus randomized bench for plugboard_config_ctrl
//                against an array-based swap-map reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_plugboard_config_ctrl;

    localparam int MAX_PAIRS = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [4:0] cmd_a = 5'd0;
    logic [4:0] cmd_b = 5'd0;
    logic       rsp_valid;
    logic [2:0] rsp_status;
    logic [3:0] pair_count;
    logic       cfg_busy;
    logic [4:0] lookup_in_0 = 5'd0;
    logic [4:0] lookup_out_0;
    logic [4:0] lookup_in_1 = 5'd0;
    logic [4:0] lookup_out_1;

    int n_checks = 0;
    int n_pass   = 0;
    int mdl [26];

    plugboard_config_ctrl #(.MAX_PAIRS(MAX_PAIRS), .N_LETTERS(26)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .rsp_valid    (rsp_valid),
        .rsp_status   (rsp_status),
        .pair_count   (pair_count),
        .cfg_busy     (cfg_busy),
        .lookup_in_0  (lookup_in_0),
        .lookup_out_0 (lookup_out_0),
        .lookup_in_1  (lookup_in_1),
        .lookup_out_1 (lookup_out_1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 26; i++) mdl[i] = i;
    endfunction

    function automatic int model_pairs();
        int n = 0;
        for (int i = 0; i < 26; i++) if (mdl[i] > i) n++;
        return n;
    endfunction

    // Applies one command to the model and returns the expected status
    function automatic int model_apply(input int op, input int a, input int b);
        int p;
        case (op)
            1: begin
                if (a > 25 || b > 25) return 1;
                if (a == b) return 2;
                if (mdl[a] != a || mdl[b] != b) return 3;
                if (model_pairs() == MAX_PAIRS) return 4;
                mdl[a] = b;
                mdl[b] = a;
                return 0;
            end
            2: begin
                if (a > 25) return 1;
                if (mdl[a] == a) return 5;
                p = mdl[a];
                mdl[a] = a;
                mdl[p] = p;
                return 0;
            end
            3: begin
                model_reset();
                return 0;
            end
            default: return 0;
        endcase
    endfunction

    task automatic check_all(input string tag);
        int e0, e1;
        for (int i = 0; i < 32; i++) begin
            lookup_in_0 = 5'(i);
            lookup_in_1 = 5'(31 - i);
            #1;
            e0 = (i < 26) ? mdl[i] : i;
            e1 = (31 - i < 26) ? mdl[31 - i] : 31 - i;
            check({tag, "_lk0"}, int'(lookup_out_0), e0);
            check({tag, "_lk1"}, int'(lookup_out_1), e1);
        end
        check({tag, "_pairs"}, int'(pair_count), model_pairs());
    endtask

    task automatic look(input int in0, input int in1, input int exp0, input int exp1);
        lookup_in_0 = 5'(in0);
        lookup_in_1 = 5'(in1);
        #1;
        check("lookup_port0", int'(lookup_out_0), exp0);
        check("lookup_port1", int'(lookup_out_1), exp1);
    endtask

    // Issues one command, holds junk on cmd_* while busy, checks timing and status
    task automatic do_cmd(input int op, input int a, input int b, input int want_st);
        int exp_st, exp_lat, lat;
        @(negedge clk);
        check("ready_before_cmd", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op = 2'(op);
        cmd_a = 5'(a);
        cmd_b = 5'(b);
        exp_st  = model_apply(op, a, b);
        exp_lat = (op == 3) ? 26 : 1;
        if (want_st >= 0) check("directed_status", exp_st, want_st);
        @(posedge clk);
        #1;
        cmd_op = 2'($urandom);
        cmd_a  = 5'($urandom);
        cmd_b  = 5'($urandom);
        check("busy_after_accept", int'(cfg_busy), 1);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (rsp_valid) break;
        end
        check("rsp_latency", lat, exp_lat);
        check("rsp_status", int'(rsp_status), exp_st);
        check("busy_in_resp", int'(cfg_busy), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("ready_after_resp", int'(cmd_ready), 1);
        check("rsp_pulse_len", int'(rsp_valid), 0);
        check("status_hold", int'(rsp_status), exp_st);
        check_all("post_cmd");
    endtask

    initial begin
        int r, op, a, b, pulses;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", int'(cmd_ready), 1);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_busy", int'(cfg_busy), 0);
        check("reset_status", int'(rsp_status), 0);
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("after_release");

        do_cmd(1, 0, 12, 0);
        do_cmd(1, 2, 13, 0);
        do_cmd(1, 3, 15, 0);
        do_cmd(1, 4, 16, 0);
        do_cmd(1, 5, 18, 0);
        do_cmd(1, 6, 21, 0);
        check("six_pairs", int'(pair_count), 6);
        look(12, 21, 0, 6);
        look(7, 7, 7, 7);

        do_cmd(1, 0, 1, 3);
        do_cmd(1, 7, 7, 2);
        do_cmd(1, 26, 3, 1);
        do_cmd(2, 7, 0, 5);
        do_cmd(0, 0, 0, 0);
        check("errors_keep_count", int'(pair_count), 6);

        do_cmd(1, 7, 8, 0);
        do_cmd(1, 9, 10, 0);
        do_cmd(1, 11, 14, 0);
        do_cmd(1, 17, 19, 0);
        check("ten_pairs", int'(pair_count), 10);
        do_cmd(1, 20, 22, 4);
        look(20, 22, 20, 22);

        do_cmd(2, 12, 0, 0);
        look(0, 12, 0, 12);
        check("remove_count", int'(pair_count), 9);
        do_cmd(2, 0, 0, 5);
        do_cmd(2, 31, 0, 1);

        do_cmd(1, 0, 12, 0);
        check("full_before_clear", int'(pair_count), 10);
        do_cmd(3, 0, 0, 0);
        check("clear_count", int'(pair_count), 0);

        do_cmd(1, 1, 2, 0);
        do_cmd(1, 24, 25, 0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 2'd3;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        check("busy_mid_clear", int'(cfg_busy), 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("abort_rsp_valid", int'(rsp_valid), 0);
        check("abort_ready", int'(cmd_ready), 1);
        check_all("abort");
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (rsp_valid) pulses++;
        end
        check("abort_no_rsp", pulses, 0);
        check("abort_ready_after", int'(cmd_ready), 1);

        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 99);
            op = (r < 50) ? 1 : (r < 82) ? 2 : (r < 96) ? 0 : 3;
            a = $urandom_range(0, 27);
            b = $urandom_range(0, 27);
            do_cmd(op, a, b, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
